bsg_manycore_remote_req_launcher: RTL and testbench

Two-stage request launcher that sits directly downstream of the EVA-to-NPA translator in the endpoint's outgoing remote-request path. It captures a core remote load/store, drives the captured EVA to the combinational translator, and filters invalid addresses. It then builds a network request packet from the returned NPA and presents it on a valid/ready port. An outstanding-request credit counter throttles launches and provides an idle indication for fences.

---
 rtl/bsg_manycore_remote_req_launcher.sv | 144 ++++++++++++++
 tb/tb_bsg_manycore_remote_req_launcher.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_remote_req_launcher.sv
// Two-stage remote request launcher: S1 holds the core request while the EVA is translated,
// S2 holds the network packet; an outstanding-request credit counter throttles launches.
module bsg_manycore_remote_req_launcher #(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 28,
    parameter int x_cord_width_p    = 7,
    parameter int y_cord_width_p    = 7,
    parameter int max_out_credits_p = 32,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
    localparam int mask_width_lp    = data_width_p / 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic                       v_i,
    output logic                       ready_o,
    input  logic                       we_i,
    input  logic [data_width_p-1:0]    eva_i,
    input  logic [data_width_p-1:0]    data_i,
    input  logic [mask_width_lp-1:0]   mask_i,
    input  logic [4:0]                 reg_id_i,

    output logic [data_width_p-1:0]    xlate_eva_o,
    input  logic [x_cord_width_p-1:0]  xlate_x_i,
    input  logic [y_cord_width_p-1:0]  xlate_y_i,
    input  logic [addr_width_p-1:0]    xlate_epa_i,
    input  logic                       xlate_invalid_i,

    input  logic [x_cord_width_p-1:0]  my_x_i,
    input  logic [y_cord_width_p-1:0]  my_y_i,

    output logic                       pkt_v_o,
    input  logic                       pkt_ready_i,
    output logic [1:0]                 pkt_op_o,
    output logic [addr_width_p-1:0]    pkt_addr_o,
    output logic [data_width_p-1:0]    pkt_data_o,
    output logic [mask_width_lp-1:0]   pkt_mask_o,
    output logic [4:0]                 pkt_reg_id_o,
    output logic [x_cord_width_p-1:0]  pkt_x_o,
    output logic [y_cord_width_p-1:0]  pkt_y_o,
    output logic [x_cord_width_p-1:0]  pkt_src_x_o,
    output logic [y_cord_width_p-1:0]  pkt_src_y_o,

    input  logic                       credit_return_i,
    output logic [credit_width_lp-1:0] out_credits_o,

    output logic                       invalid_v_o,
    output logic [data_width_p-1:0]    invalid_eva_o,
    output logic                       idle_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
    localparam logic [credit_width_lp-1:0] one_credit_lp  = credit_width_lp'(1);

    logic                     s1_v;
    logic                     s1_we;
    logic [data_width_p-1:0]  s1_data;
    logic [mask_width_lp-1:0] s1_mask;
    logic [4:0]               s1_reg_id;

    logic s1_invalid, s1_move, s1_leave, accept;

    // The move condition uses the registered credit count, so a returned credit
    // only enables a move on the following cycle.
    assign s1_invalid = s1_v & xlate_invalid_i;
    assign s1_move    = s1_v & ~xlate_invalid_i & (out_credits_o != '0) & (~pkt_v_o | pkt_ready_i);
    assign s1_leave   = s1_invalid | s1_move;
    assign ready_o    = ~s1_v | s1_leave;
    assign accept     = v_i & ready_o;

    // NOTE: every register in this file is written with non-blocking assignments so
    // all stages sample the pre-edge values of each other, giving true pipelining.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v        <= 1'b0;
            s1_we       <= 1'b0;
            xlate_eva_o <= '0;
            s1_data     <= '0;
            s1_mask     <= '0;
            s1_reg_id   <= '0;
        end else if (accept) begin
            s1_v        <= 1'b1;
            s1_we       <= we_i;
            xlate_eva_o <= eva_i;
            s1_data     <= data_i;
            s1_mask     <= mask_i;
            s1_reg_id   <= reg_id_i;
        end else if (s1_leave) begin
            s1_v <= 1'b0;
        end
    end

    // Packet fields only change on a refill, so they stay stable under backpressure.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_v_o      <= 1'b0;
            pkt_op_o     <= '0;
            pkt_addr_o   <= '0;
            pkt_data_o   <= '0;
            pkt_mask_o   <= '0;
            pkt_reg_id_o <= '0;
            pkt_x_o      <= '0;
            pkt_y_o      <= '0;
            pkt_src_x_o  <= '0;
            pkt_src_y_o  <= '0;
        end else if (s1_move) begin
            pkt_v_o      <= 1'b1;
            pkt_op_o     <= {1'b0, s1_we};
            pkt_addr_o   <= xlate_epa_i;
            pkt_data_o   <= s1_we ? s1_data : '0;
            pkt_mask_o   <= s1_mask;
            pkt_reg_id_o <= s1_reg_id;
            pkt_x_o      <= xlate_x_i;
            pkt_y_o      <= xlate_y_i;
            pkt_src_x_o  <= my_x_i;
            pkt_src_y_o  <= my_y_i;
        end else if (pkt_ready_i) begin
            pkt_v_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_credits_o <= max_credits_lp;
        end else if (s1_move & ~credit_return_i) begin
            out_credits_o <= out_credits_o - one_credit_lp;
        end else if (credit_return_i & ~s1_move & (out_credits_o != max_credits_lp)) begin
            out_credits_o <= out_credits_o + one_credit_lp;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            invalid_v_o   <= 1'b0;
            invalid_eva_o <= '0;
        end else begin
            invalid_v_o <= s1_invalid;
            if (s1_invalid) invalid_eva_o <= xlate_eva_o;
        end
    end

    assign idle_o = ~s1_v & ~pkt_v_o & (out_credits_o == max_credits_lp);

endmodule

// File: tb/tb_bsg_manycore_remote_req_launcher.sv
// Bench for bsg_manycore_remote_req_launcher: directed scenarios plus a randomized phase,
// with a packet/fault scoreboard filled from accepted requests and a simple translator model.
module tb_bsg_manycore_remote_req_launcher;

    typedef struct packed {
        logic [1:0]  op;
        logic [27:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [4:0]  rid;
        logic [6:0]  x;
        logic [6:0]  y;
        logic [6:0]  sx;
        logic [6:0]  sy;
    } pkt_t;

    localparam logic [6:0] my_x_c = 7'd3;
    localparam logic [6:0] my_y_c = 7'd5;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        v_i = 1'b0, we_i = 1'b0;
    logic [31:0] eva_i = '0, data_i = '0;
    logic [3:0]  mask_i = '0;
    logic [4:0]  reg_id_i = '0;
    logic        ready_o;
    logic [31:0] xlate_eva_o;
    logic [6:0]  xlate_x_i, xlate_y_i;
    logic [27:0] xlate_epa_i;
    logic        xlate_invalid_i;
    logic        pkt_v_o, pkt_ready_i = 1'b1;
    logic [1:0]  pkt_op_o;
    logic [27:0] pkt_addr_o;
    logic [31:0] pkt_data_o;
    logic [3:0]  pkt_mask_o;
    logic [4:0]  pkt_reg_id_o;
    logic [6:0]  pkt_x_o, pkt_y_o, pkt_src_x_o, pkt_src_y_o;
    logic        credit_return_i = 1'b0;
    logic [5:0]  out_credits_o;
    logic        invalid_v_o;
    logic [31:0] invalid_eva_o;
    logic        idle_o;

    bsg_manycore_remote_req_launcher dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(v_i), .ready_o(ready_o), .we_i(we_i), .eva_i(eva_i), .data_i(data_i),
        .mask_i(mask_i), .reg_id_i(reg_id_i),
        .xlate_eva_o(xlate_eva_o), .xlate_x_i(xlate_x_i), .xlate_y_i(xlate_y_i),
        .xlate_epa_i(xlate_epa_i), .xlate_invalid_i(xlate_invalid_i),
        .my_x_i(my_x_c), .my_y_i(my_y_c),
        .pkt_v_o(pkt_v_o), .pkt_ready_i(pkt_ready_i), .pkt_op_o(pkt_op_o),
        .pkt_addr_o(pkt_addr_o), .pkt_data_o(pkt_data_o), .pkt_mask_o(pkt_mask_o),
        .pkt_reg_id_o(pkt_reg_id_o), .pkt_x_o(pkt_x_o), .pkt_y_o(pkt_y_o),
        .pkt_src_x_o(pkt_src_x_o), .pkt_src_y_o(pkt_src_y_o),
        .credit_return_i(credit_return_i), .out_credits_o(out_credits_o),
        .invalid_v_o(invalid_v_o), .invalid_eva_o(invalid_eva_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    // Translator model: EVA 0 or bit 31 set is unmapped; x from bits 22:16, y = x+1,
    // EPA is the word index from bits 15:2.
    function automatic logic eva_bad(input logic [31:0] eva);
        return (eva == 32'h0) || eva[31];
    endfunction

    assign xlate_invalid_i = eva_bad(xlate_eva_o);
    assign xlate_x_i       = xlate_eva_o[22:16];
    assign xlate_y_i       = xlate_eva_o[22:16] + 7'd1;
    assign xlate_epa_i     = {14'b0, xlate_eva_o[15:2]};

    int n_cmp = 0, n_bad = 0;
    int launched_total = 0, inv_pulses = 0;
    pkt_t        pkt_q[$];
    logic [31:0] inv_q[$];
    pkt_t        cur, prev;
    bit          held = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records accepted requests as expected packets/faults and scores the outputs.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            held = 1'b0;
        end else begin
            if (v_i && ready_o) begin
                if (eva_bad(eva_i)) inv_q.push_back(eva_i);
                else pkt_q.push_back('{op: {1'b0, we_i}, addr: {14'b0, eva_i[15:2]},
                                       data: we_i ? data_i : 32'h0, mask: mask_i, rid: reg_id_i,
                                       x: eva_i[22:16], y: eva_i[22:16] + 7'd1,
                                       sx: my_x_c, sy: my_y_c});
            end
            cur = '{pkt_op_o, pkt_addr_o, pkt_data_o, pkt_mask_o, pkt_reg_id_o,
                    pkt_x_o, pkt_y_o, pkt_src_x_o, pkt_src_y_o};
            if (held) check("pkt_stable", 128'(cur), 128'(prev));
            if (pkt_v_o && pkt_ready_i) begin
                check("pkt_expected_present", 128'(pkt_q.size() != 0), 128'(1));
                if (pkt_q.size() != 0) check("pkt_fields", 128'(cur), 128'(pkt_q.pop_front()));
                launched_total++;
            end
            if (invalid_v_o) begin
                inv_pulses++;
                check("inv_expected_present", 128'(inv_q.size() != 0), 128'(1));
                if (inv_q.size() != 0) check("inv_eva", 128'(invalid_eva_o), 128'(inv_q.pop_front()));
            end
            held = pkt_v_o && !pkt_ready_i;
            prev = cur;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Presents one request; returns ok=0 if it is not accepted within budget cycles.
    task automatic send(input logic we, input logic [31:0] eva, input logic [31:0] data,
                        input logic [3:0] mask, input logic [4:0] rid, input int budget,
                        output bit ok);
        v_i = 1'b1; we_i = we; eva_i = eva; data_i = data; mask_i = mask; reg_id_i = rid;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_i);
            if (ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
    endtask

    task automatic send_ok(input string tag, input logic we, input logic [31:0] eva);
        bit ok;
        send(we, eva, $urandom, 4'($urandom), 5'($urandom), 40, ok);
        check(tag, 128'(ok), 128'(1));
    endtask

    task automatic ret(input int n);
        credit_return_i = 1'b1;
        cyc(n);
        credit_return_i = 1'b0;
    endtask

    function automatic logic [31:0] good_eva();
        return ($urandom & 32'h7FFF_FFFF) | 32'h4;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  l0, p0, acc, rr;
        bit  ok, done;

        // Reset state
        cyc(1);
        check("rst_ready", 128'(ready_o), 128'(1));
        check("rst_pkt_v", 128'(pkt_v_o), 128'(0));
        check("rst_pkt_fields", 128'({pkt_op_o, pkt_addr_o, pkt_data_o, pkt_mask_o, pkt_reg_id_o,
                                      pkt_x_o, pkt_y_o, pkt_src_x_o, pkt_src_y_o}), 128'(0));
        check("rst_credits", 128'(out_credits_o), 128'(32));
        check("rst_inv", 128'({invalid_v_o, invalid_eva_o}), 128'(0));
        check("rst_idle", 128'(idle_o), 128'(1));
        check("rst_xlate_eva", 128'(xlate_eva_o), 128'(0));
        cyc(1);
        reset_n_i = 1'b1;
        cyc(1);

        // Single store: latency N+2, translated fields, credit round trip
        send(1'b1, 32'h0001_0040, 32'hDEAD_BEEF, 4'hF, 5'd3, 4, ok);
        check("t1_accept", 128'(ok), 128'(1));
        check("t1_pkt_v_n1", 128'(pkt_v_o), 128'(0));
        cyc(1);
        check("t1_pkt_v_n2", 128'(pkt_v_o), 128'(1));
        check("t1_pkt", 128'({pkt_op_o, pkt_addr_o, pkt_x_o, pkt_y_o, pkt_data_o}),
              128'({2'd1, 28'h10, 7'd1, 7'd2, 32'hDEAD_BEEF}));
        check("t1_credits", 128'(out_credits_o), 128'(31));
        check("t1_not_idle", 128'(idle_o), 128'(0));
        cyc(1);
        ret(1);
        check("t1_credits_back", 128'(out_credits_o), 128'(32));
        check("t1_idle_back", 128'(idle_o), 128'(1));

        // 40 back-to-back loads, no returns: 33 accepted, 32 launched
        l0 = launched_total; acc = 0;
        for (int i = 0; i < 40; i++) begin
            send(1'b0, good_eva(), $urandom, 4'($urandom), 5'(i), 8, ok);
            if (!ok) break;
            acc++;
        end
        check("t2_accepted", 128'(acc), 128'(33));
        check("t2_launched", 128'(launched_total - l0), 128'(32));
        check("t2_credits0", 128'(out_credits_o), 128'(0));
        check("t2_ready_low", 128'(ready_o), 128'(0));
        ret(1);
        check("t2_m1_pkt_v", 128'(pkt_v_o), 128'(0));
        check("t2_m1_credits", 128'(out_credits_o), 128'(1));
        cyc(1);
        check("t2_m2_pkt_v", 128'(pkt_v_o), 128'(1));
        check("t2_m2_credits", 128'(out_credits_o), 128'(0));
        cyc(3);
        check("t2_launched_one_more", 128'(launched_total - l0), 128'(33));
        ret(32);
        check("t2_credits_full", 128'(out_credits_o), 128'(32));
        check("t2_idle", 128'(idle_o), 128'(1));

        // Invalid EVA between two valid requests
        l0 = launched_total; p0 = inv_pulses;
        send_ok("t3_acc_a", 1'b1, good_eva());
        send_ok("t3_acc_inv", 1'b0, 32'h0);
        send_ok("t3_acc_b", 1'b0, good_eva());
        cyc(6);
        check("t3_pulses", 128'(inv_pulses - p0), 128'(1));
        check("t3_inv_eva", 128'(invalid_eva_o), 128'(0));
        check("t3_launched", 128'(launched_total - l0), 128'(2));
        check("t3_credits", 128'(out_credits_o), 128'(30));
        send_ok("t3_acc_inv2", 1'b1, 32'h8000_1234);
        cyc(6);
        check("t3_inv_eva_held", 128'(invalid_eva_o), 128'(32'h8000_1234));
        check("t3_pulses2", 128'(inv_pulses - p0), 128'(2));
        check("t3_credits2", 128'(out_credits_o), 128'(30));
        ret(2);

        // Backpressure with three requests pending
        l0 = launched_total;
        pkt_ready_i = 1'b0;
        fork
            begin
                send_ok("t4_acc0", 1'b1, good_eva());
                send_ok("t4_acc1", 1'b0, good_eva());
                send_ok("t4_acc2", 1'b1, good_eva());
            end
            begin
                cyc(5);
                check("t4_ready_low", 128'(ready_o), 128'(0));
                check("t4_none_launched", 128'(launched_total - l0), 128'(0));
                pkt_ready_i = 1'b1;
            end
        join
        cyc(6);
        check("t4_launched", 128'(launched_total - l0), 128'(3));
        check("t4_credits", 128'(out_credits_o), 128'(29));
        ret(3);

        // Simultaneous move and return at 5 credits; return at max saturates
        for (int i = 0; i < 27; i++) send_ok("t5_fill", 1'b0, good_eva());
        cyc(4);
        check("t5_credits5", 128'(out_credits_o), 128'(5));
        send_ok("t5_acc", 1'b1, good_eva());
        ret(1);
        check("t5_move_and_return", 128'(out_credits_o), 128'(5));
        cyc(3);
        ret(27);
        check("t5_full", 128'(out_credits_o), 128'(32));
        ret(1);
        check("t5_saturate", 128'(out_credits_o), 128'(32));

        // Asynchronous reset with S1 and S2 full
        l0 = launched_total;
        pkt_ready_i = 1'b0;
        send_ok("t6_acc0", 1'b1, good_eva());
        send_ok("t6_acc1", 1'b0, good_eva());
        #2;
        reset_n_i = 1'b0;
        #1;
        pkt_q.delete();
        inv_q.delete();
        check("t6_pkt_v_drop", 128'(pkt_v_o), 128'(0));
        check("t6_credits", 128'(out_credits_o), 128'(32));
        check("t6_idle", 128'(idle_o), 128'(1));
        check("t6_ready", 128'(ready_o), 128'(1));
        cyc(2);
        reset_n_i = 1'b1;
        pkt_ready_i = 1'b1;
        cyc(5);
        check("t6_no_ghost", 128'(launched_total - l0), 128'(0));
        check("t6_pkt_v_after", 128'(pkt_v_o), 128'(0));

        // Randomized traffic with random backpressure and credit returns
        l0 = launched_total; rr = 0; done = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    logic [31:0] eva;
                    if ($urandom_range(7) == 0) eva = $urandom_range(1) ? 32'h0 : (32'h8000_0000 | $urandom);
                    else eva = good_eva();
                    send(1'($urandom), eva, $urandom, 4'($urandom), 5'($urandom), 300, ok);
                    check("rnd_accept", 128'(ok), 128'(1));
                    if ($urandom_range(3) == 0) cyc($urandom_range(3));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_i);
                    if (credit_return_i) rr++;
                    #1;
                    pkt_ready_i = ($urandom_range(3) != 0);
                    credit_return_i = ((launched_total - l0 - rr) > 0) && ($urandom_range(2) == 0);
                end
            end
        join
        @(posedge clk_i);
        if (credit_return_i) rr++;
        #1;
        credit_return_i = 1'b0;
        pkt_ready_i = 1'b1;
        cyc(10);
        check("rnd_pkt_q_empty", 128'(pkt_q.size()), 128'(0));
        check("rnd_inv_q_empty", 128'(inv_q.size()), 128'(0));
        check("rnd_credits", 128'(out_credits_o), 128'(32 - (launched_total - l0 - rr)));
        if (launched_total - l0 - rr > 0) ret(launched_total - l0 - rr);
        check("rnd_credits_full", 128'(out_credits_o), 128'(32));
        check("rnd_idle", 128'(idle_o), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
